// File: rtl/ring_decoder.sv
// Ring-counter decoder: validates rotate-left one-hot codes, reports the
// set-bit index, tracks sequence lock, and counts sequence errors.
module ring_decoder #(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CNT_W    = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [IDX_W-1:0] index,
  output logic             onehot_ok,
  output logic             locked,
  output logic             seq_err,
  output logic [7:0]       err_count
);

  // state  | meaning
  // HUNT   | no trusted ring position; waiting for any one-hot sample
  // SYNC   | one-hot seen; counting consecutive correct advances
  // LOCKED | LOCK_CNT correct advances seen; ring is tracking
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               onehot_ok_q, onehot_ok_d;
  logic               seq_err_q, seq_err_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               is_onehot;
  logic [IDX_W-1:0]   hot_idx;
  logic [WIDTH-1:0]   rotl_prev;
  logic               mismatch;
  logic [CNT_W-1:0]   match_inc;

  // Sample decode: zero and multi-bit codes are both invalid.
  always_comb begin
    is_onehot = (data_in != '0) && ((data_in & (data_in - WIDTH'(1))) == '0);
    hot_idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_in[i]) hot_idx = IDX_W'(i);
    end
  end

  generate
    if (WIDTH > 1) begin : g_rotl
      assign rotl_prev = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    end else begin : g_rotl1
      assign rotl_prev = prev_q;
    end
  endgenerate

  // A stalled ring (sample == prev) also fails this compare.
  assign mismatch  = prev_valid_q && (data_in != rotl_prev);
  assign match_inc = match_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (is_onehot) begin
            state_d     = SYNC;
            match_cnt_d = '0;
          end
        end
        SYNC: begin
          if (!is_onehot) begin
            state_d     = HUNT;
            match_cnt_d = '0;
          end else if (mismatch) begin
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_inc;
            if (match_inc >= CNT_W'(LOCK_CNT)) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (!is_onehot) begin
            state_d     = HUNT;
            match_cnt_d = '0;
          end else if (mismatch) begin
            state_d     = SYNC;
            match_cnt_d = '0;
          end
        end
        default: begin
          state_d     = HUNT;
          match_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    index_d      = index_q;
    onehot_ok_d  = onehot_ok_q;
    seq_err_d    = 1'b0;
    err_count_d  = err_count_q;
    if (en) begin
      prev_valid_d = is_onehot;
      onehot_ok_d  = is_onehot;
      seq_err_d    = !is_onehot || mismatch;
      if (is_onehot) begin
        prev_d  = data_in;
        index_d = hot_idx;
      end
      if (seq_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= HUNT;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      match_cnt_q  <= '0;
      index_q      <= '0;
      onehot_ok_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      match_cnt_q  <= match_cnt_d;
      index_q      <= index_d;
      onehot_ok_q  <= onehot_ok_d;
      seq_err_q    <= seq_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign index     = index_q;
  assign onehot_ok = onehot_ok_q;
  assign locked    = (state_q == LOCKED);
  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;

endmodule

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001: Parameter WIDTH, default 4, is the ring length in bits; the index width is log2(WIDTH), which is 2 at the default.
REQ-002: Parameter LOCK_CNT, default 3, is the number of consecutive correct ring advances needed to declare lock.
REQ-003: Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004: Port reset, input, 1 bit: synchronous, active-low reset; reset=0 at a rising edge of clk resets the block.
REQ-005: Port en, input, 1 bit: sample enable; data_in is evaluated only on edges where en=1.
REQ-006: Port data_in, input, WIDTH bits: ring-counter code under decode.
REQ-007: Port index, output, log2(WIDTH) bits: binary position of the set bit in the last valid one-hot sample.
REQ-008: Port onehot_ok, output, 1 bit: the last sample had exactly one bit set.
REQ-009: Port locked, output, 1 bit: the decoder is in state LOCKED.
REQ-010: Port seq_err, output, 1 bit: one-cycle pulse flagging an invalid or out-of-sequence sample.
REQ-011: Port err_count, output, 8 bits: saturating count of seq_err pulses.

Function
REQ-012: All outputs SHALL be registered, with a latency of one clk edge from the sampling edge.
REQ-013: The legal ring sequence SHALL be rotate-left: next = {d[WIDTH-2:0], d[WIDTH-1]}, i.e. 0001 -> 0010 -> 0100 -> 1000 -> 0001.
REQ-014: A sample SHALL be one-hot when exactly one bit is set; 0000 and any value with two or more bits set are invalid.
REQ-015: On a one-hot sample, index SHALL take the set-bit position and onehot_ok SHALL be 1.
REQ-016: On an invalid sample, index SHALL hold its previous value and onehot_ok SHALL be 0.
REQ-017: The block SHALL keep a prev register and a prev_valid flag; prev_valid=1 only when the last enabled sample was one-hot.
REQ-018: seq_err SHALL pulse for one cycle when the sample is invalid.
REQ-019: seq_err SHALL also pulse for one cycle when prev_valid=1 and the sample differs from rotl(prev).
REQ-020: A repeated sample (stalled ring) SHALL count as a mismatch.
REQ-021: seq_err SHALL be 0 on every other cycle, including every cycle with en=0.
REQ-022: err_count SHALL increment by 1 on each seq_err pulse and saturate at 255 without wrapping.
REQ-023: FSM state HUNT: a one-hot sample moves to SYNC with match_cnt=0; an invalid sample stays in HUNT.
REQ-024: FSM state SYNC, correct successor: match_cnt increments; when it reaches LOCK_CNT, the FSM moves to LOCKED.
REQ-025: FSM state SYNC, one-hot mismatch: stay in SYNC with match_cnt=0.
REQ-026: FSM state SYNC, invalid sample: move to HUNT.
REQ-027: FSM state LOCKED, correct successor: stay in LOCKED.
REQ-028: FSM state LOCKED, one-hot mismatch: move to SYNC with match_cnt=0.
REQ-029: FSM state LOCKED, invalid sample: move to HUNT.
REQ-030: locked SHALL be 1 exactly while the FSM is in LOCKED.
REQ-031: With en=0, the FSM, prev, prev_valid, match_cnt, index, onehot_ok and err_count SHALL all hold; gaps in en are not errors.
REQ-032: The successor check after an en gap SHALL compare against the last enabled sample.

Reset
REQ-033: reset=0 at an edge SHALL force index=0, onehot_ok=0, locked=0, seq_err=0, err_count=0, FSM=HUNT, prev=0, prev_valid=0, match_cnt=0.
REQ-034: Reset SHALL take priority over en and data_in, including mid-lock.
REQ-035: The first enabled sample after reset SHALL never raise a mismatch error; only invalidity can flag it.

Verification
REQ-036: Lock-up: reset=0 for 2 cycles, then en=1 with 0001,0010,0100,1000,0001 -> index 0,1,2,3,0; onehot_ok=1 throughout; locked=1 from the output following the 4th sample; seq_err stays 0.
REQ-037: Invalid code: while locked, drive 0101 -> one seq_err pulse, onehot_ok=0, index held, locked=0 (HUNT), err_count=1.
REQ-038: Stall: while locked, drive 0100 twice -> seq_err pulses on the second sample, locked=0 (SYNC), err_count increments by 1; a correct sequence then relocks after 3 correct advances.
REQ-039: Enable gap: while locked at 0010, hold en=0 for 3 cycles, then drive 0100 -> no seq_err and locked stays 1.
REQ-040: Saturation: drive 0000 continuously for 260 enabled cycles -> err_count=255 and holds at 255.
REQ-041: Mid-lock reset: assert reset=0 for 1 cycle while locked -> all outputs are 0 after that edge, and the next sample enters SYNC without an error.
